// File: rtl/audioplay_button_conditioner.sv
// Purpose: clean up one raw active-low key into a debounced level, counted press events and a stretched PIO pulse.
// Latency: press_out rises DEBOUNCE_CYCLES+3 edges after button_n is first sampled low; pressed rises one edge earlier.
// Backpressure: none; press_out is a level that the polling software samples, and retriggers extend it without a gap.
module audioplay_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 2500000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_n,
    output logic       press_out,
    output logic       pressed,
    output logic [7:0] press_count
);

    localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCW    = $clog2(HOLD_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW    = $clog2(RP_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [RPW-1:0] RD_LAST   = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RP_LAST   = RPW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic           sync1;
    logic           sync2;
    logic           key;
    logic           stable;
    logic [DBW-1:0] db_cnt;
    state_t         state_q;
    state_t         state_d;
    logic [RPW-1:0] rp_cnt_q;
    logic [RPW-1:0] rp_cnt_d;
    logic           press_evt;
    logic [HCW-1:0] hold_cnt;

    // Two-flop synchronizer; resets to the released level so a held key is seen only after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
        end
    end

    assign key = ~sync2;

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (key == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= key;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign pressed = stable;

    // Event FSM state and shared delay/repeat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rp_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rp_cnt_q <= rp_cnt_d;
        end
    end

    // Event FSM next state: release is checked first, so it beats a same-cycle repeat.
    always_comb begin
        state_d   = state_q;
        rp_cnt_d  = rp_cnt_q;
        press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable) begin
                    press_evt = 1'b1;
                    rp_cnt_d  = '0;
                    state_d   = REPEAT_EN ? DELAY : REPEAT;
                end
            end
            DELAY: begin
                if (!stable) begin
                    state_d = IDLE;
                end else if (rp_cnt_q == RD_LAST) begin
                    press_evt = 1'b1;
                    rp_cnt_d  = '0;
                    state_d   = REPEAT;
                end else begin
                    rp_cnt_d = rp_cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!stable) begin
                    state_d = IDLE;
                end else if (REPEAT_EN && (rp_cnt_q == RP_LAST)) begin
                    press_evt = 1'b1;
                    rp_cnt_d  = '0;
                end else begin
                    rp_cnt_d = rp_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulse stretcher and event counter; a new event reloads the hold time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_out   <= 1'b0;
            hold_cnt    <= '0;
            press_count <= 8'd0;
        end else if (press_evt) begin
            press_out   <= 1'b1;
            hold_cnt    <= HOLD_LAST;
            press_count <= press_count + 8'd1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end else begin
            press_out <= 1'b0;
        end
    end

endmodule
